fetch_unit: RTL

Instruction-fetch stage directly upstream of the decode stage. Holds the PC and issues word requests to instruction memory over a req/ack handshake. Presents the fetched instruction and its pre-split register fields (rs/rt/rd) plus opcode, funct and imm16 to decode. Supports back-pressure from downstream (stall) and PC redirect for branches and jumps.

---
 rtl/fetch_unit.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch: PC + imem req/ack handshake, 1-entry skid, pre-split decode fields.
// Latency ack->o_valid 1 cycle at 1 instr/cycle; i_stall freezes output, a full skid drops the request.
module fetch_unit #(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(32'h0040_0000)
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_stall,
    input  logic              i_redirect,
    input  logic [ADDR_W-1:0] i_redirect_pc,
    output logic              o_imem_req,
    output logic [ADDR_W-1:0] o_imem_addr,
    input  logic              i_imem_ack,
    input  logic [31:0]       i_imem_rdata,
    output logic              o_valid,
    output logic [31:0]       o_instr,
    output logic [ADDR_W-1:0] o_pc,
    output logic [ADDR_W-1:0] o_pc_plus4,
    output logic [5:0]        o_opcode,
    output logic [4:0]        o_rs,
    output logic [4:0]        o_rt,
    output logic [4:0]        o_rd,
    output logic [5:0]        o_funct,
    output logic [15:0]       o_imm16
);

    localparam logic [ADDR_W-1:0] WORD_BYTES = ADDR_W'(4);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_HOLD} state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [31:0]       instr;
    } entry_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] pend_pc_q, pend_pc_d;
    logic              squash_q, squash_d;
    entry_t            out_q, out_d;
    entry_t            skid_q, skid_d;
    logic              out_vld_q, out_vld_d;
    logic              skid_vld_q, skid_vld_d;

    logic              consume;
    logic              ack_fire;
    entry_t            fetched;
    logic [ADDR_W-1:0] redir_pc;
    logic              redir_lsb_unused;

    assign consume          = out_vld_q && !i_stall;
    assign ack_fire         = (state_q == S_REQ) && i_imem_ack;
    assign fetched          = {pc_q, i_imem_rdata};
    assign redir_pc         = {i_redirect_pc[ADDR_W-1:2], 2'b00};
    assign redir_lsb_unused = ^i_redirect_pc[1:0];

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        pend_pc_d  = pend_pc_q;
        squash_d   = squash_q;
        out_d      = out_q;
        out_vld_d  = out_vld_q;
        skid_d     = skid_q;
        skid_vld_d = skid_vld_q;

        if (i_redirect) begin
            out_vld_d  = 1'b0;
            skid_vld_d = 1'b0;
            state_d    = S_REQ;
            // A request already on the bus must complete at its old address;
            // its data is dropped and the new target is fetched afterwards.
            if (state_q == S_REQ && !i_imem_ack) begin
                squash_d  = 1'b1;
                pend_pc_d = redir_pc;
            end else begin
                squash_d = 1'b0;
                pc_d     = redir_pc;
            end
        end else begin
            if (consume) begin
                out_d      = skid_q;
                out_vld_d  = skid_vld_q;
                skid_vld_d = 1'b0;
            end

            if (ack_fire) begin
                if (squash_q) begin
                    squash_d = 1'b0;
                    pc_d     = pend_pc_q;
                end else begin
                    pc_d = pc_q + WORD_BYTES;
                    if (!out_vld_q || (consume && !skid_vld_q)) begin
                        out_d     = fetched;
                        out_vld_d = 1'b1;
                    end else begin
                        skid_d     = fetched;
                        skid_vld_d = 1'b1;
                    end
                end
            end

            case (state_q)
                S_IDLE:  state_d = S_REQ;
                S_REQ:   state_d = skid_vld_d ? S_HOLD : S_REQ;
                S_HOLD:  state_d = skid_vld_d ? S_HOLD : S_REQ;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= S_IDLE;
            pc_q       <= {RESET_PC[ADDR_W-1:2], 2'b00};
            pend_pc_q  <= {RESET_PC[ADDR_W-1:2], 2'b00};
            squash_q   <= 1'b0;
            out_q      <= '0;
            out_vld_q  <= 1'b0;
            skid_q     <= '0;
            skid_vld_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            pend_pc_q  <= pend_pc_d;
            squash_q   <= squash_d;
            out_q      <= out_d;
            out_vld_q  <= out_vld_d;
            skid_q     <= skid_d;
            skid_vld_q <= skid_vld_d;
        end
    end

    assign o_imem_req  = (state_q == S_REQ);
    assign o_imem_addr = pc_q;

    assign o_valid    = out_vld_q;
    assign o_instr    = out_q.instr;
    assign o_pc       = out_q.pc;
    assign o_pc_plus4 = out_q.pc + WORD_BYTES;
    assign o_opcode   = out_q.instr[31:26];
    assign o_rs       = out_q.instr[25:21];
    assign o_rt       = out_q.instr[20:16];
    assign o_rd       = out_q.instr[15:11];
    assign o_funct    = out_q.instr[5:0];
    assign o_imm16    = out_q.instr[15:0];

endmodule
